// File: rtl/shift_pkg.sv
// Shared encodings and the per-stage payload record for the shift pipeline.
// Payload fields are sized for the largest build (64-bit data, 16-bit tag); narrower builds zero the upper bits.
package shift_pkg;

    localparam int MAX_W    = 64;
    localparam int MAX_TAGW = 16;
    localparam int MAX_SHW  = 6;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } sh_mode_e;

    typedef struct packed {
        logic                valid;
        sh_mode_e            mode;
        logic                fill;
        logic                oor;
        logic [MAX_TAGW-1:0] tag;
        logic [MAX_W-1:0]    data;
        logic [MAX_SHW-1:0]  amt;
    } stage_pay_t;

    localparam int PAY_W = $bits(stage_pay_t);

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter level: shifts by 2^K when amount bit K is set, then registers the payload.
// Latency: 1 cycle.
// Backpressure: the register loads only while advance is high, otherwise it holds.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic [PAY_W-1:0] pay_in,
    output logic [PAY_W-1:0] pay_out
);

    localparam int S    = 1 << K;
    localparam bit LAST = (K == $clog2(WIDTH) - 1);

    stage_pay_t       p_in;
    stage_pay_t       pay_d;
    stage_pay_t       pay_q;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] sh;

    always_comb begin
        p_in = stage_pay_t'(pay_in);
        w    = p_in.data[WIDTH-1:0];
        sh   = w;
        if (p_in.amt[K]) begin
            case (p_in.mode)
                SH_SLL:  sh = w << S;
                SH_SRL:  sh = w >> S;
                SH_SRA:  sh = (w >> S) | ({WIDTH{p_in.fill}} << (WIDTH - S));
                default: sh = (w >> S) | (w << (WIDTH - S));
            endcase
        end
        // Oversized amounts were flagged at acceptance; the last level overrides the shifted value.
        if (LAST && p_in.oor && (p_in.mode != SH_ROR)) begin
            sh = (p_in.mode == SH_SRA) ? {WIDTH{p_in.fill}} : '0;
        end
        pay_d                  = p_in;
        pay_d.data             = '0;
        pay_d.data[WIDTH-1:0]  = sh;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pay_q <= '0;
        end else if (advance) begin
            pay_q <= pay_d;
        end
    end

    assign pay_out = pay_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROR shifter with a tag carried alongside each operation.
// Latency: log2(WIDTH) cycles from acceptance to out_valid; 1 op/cycle throughput.
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready mirrors that.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [31:0]      in_b,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [TAGW-1:0]  out_tag
);

    localparam int SHW = $clog2(WIDTH);

    logic [PAY_W-1:0] chain [SHW+1];
    stage_pay_t       in_pay;
    stage_pay_t       last;
    logic             advance;
    logic             unused_pay;

    always_comb begin
        in_pay                 = '0;
        in_pay.valid           = in_valid;
        in_pay.mode            = sh_mode_e'(in_mode);
        in_pay.fill            = in_a[WIDTH-1];
        in_pay.oor             = |in_b[31:SHW];
        in_pay.tag[TAGW-1:0]   = in_tag;
        in_pay.data[WIDTH-1:0] = in_a;
        in_pay.amt[SHW-1:0]    = in_b[SHW-1:0];
    end

    assign chain[0] = in_pay;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .advance (advance),
            .pay_in  (chain[k]),
            .pay_out (chain[k+1])
        );
    end

    assign last      = stage_pay_t'(chain[SHW]);
    assign out_valid = last.valid;
    assign out_res   = last.data[WIDTH-1:0];
    assign out_tag   = last.tag[TAGW-1:0];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    // Control fields and padding of the final payload are not needed at the output.
    assign unused_pay = ^{last.data, last.tag, last.amt, last.mode, last.fill, last.oor};

endmodule

// File: tb/tb_shift_pipe.sv
module tb_shift_pipe;

    localparam int SHW = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_mode;
    logic [31:0] in_a, in_b, out_res;
    logic [3:0]  in_tag, out_tag;

    logic        in_valid8, in_ready8, out_valid8;
    logic [1:0]  in_mode8;
    logic [7:0]  in_a8, out_res8;
    logic [31:0] in_b8;
    logic [3:0]  in_tag8, out_tag8;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(32), .TAGW(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag)
    );

    shift_pipe #(.WIDTH(8), .TAGW(4)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_mode(in_mode8), .in_a(in_a8), .in_b(in_b8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(1'b1), .out_res(out_res8), .out_tag(out_tag8)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        int          acc;
        bit          chk;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic [3:0]  prev_tag;

    logic [1:0]  vm [8];
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vr [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per handshake, and polices stalls.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                check("hold_res", {32'd0, out_res}, {32'd0, prev_res});
                check("hold_tag", {60'd0, out_tag}, {60'd0, prev_tag});
            end
            if (out_valid && !out_ready) begin
                stall_cnt++;
                check("in_ready_stall", {63'd0, in_ready}, 64'd0);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual tag=%0d res=0x%0h expected no output", out_tag, out_res);
                end else begin
                    mon_e = sbq.pop_front();
                    check("out_res", {32'd0, out_res}, {32'd0, mon_e.res});
                    check("out_tag", {60'd0, out_tag}, {60'd0, mon_e.tag});
                    if (mon_e.chk) check("latency", 64'(cyc - mon_e.acc), 64'(SHW));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_res;
            prev_tag   = out_tag;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Called at posedge+1; returns at the posedge+1 after acceptance.
    task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] exp, input bit push, input bit chk);
        int waitc = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual in_ready=0 expected 1 tag=%0d", tag);
        end else if (push) begin
            sbq.push_back('{exp, tag, cyc, chk});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        check("drain", 64'(sbq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input string name, input logic [7:0] a, input logic [31:0] b, input logic [7:0] exp);
        int n = 0;
        in_valid8 = 1'b1;
        in_mode8  = 2'b00;
        in_a8     = a;
        in_b8     = b;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        n = 1;
        while (!out_valid8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_lat"}, 64'(n), 64'd3);
        check({name, "_res"}, {56'd0, out_res8}, {56'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        vm[0] = 2'b10; va[0] = 32'h8000_0000; vb[0] = 32'h0000_0020; vr[0] = 32'hFFFF_FFFF;
        vm[1] = 2'b01; va[1] = 32'h8000_0000; vb[1] = 32'h0000_0020; vr[1] = 32'h0000_0000;
        vm[2] = 2'b11; va[2] = 32'h1234_5678; vb[2] = 32'd36;        vr[2] = 32'h8123_4567;
        vm[3] = 2'b00; va[3] = 32'h0000_0003; vb[3] = 32'd31;        vr[3] = 32'h8000_0000;
        vm[4] = 2'b10; va[4] = 32'hF000_0000; vb[4] = 32'd4;         vr[4] = 32'hFF00_0000;
        vm[5] = 2'b11; va[5] = 32'hDEAD_BEEF; vb[5] = 32'd0;         vr[5] = 32'hDEAD_BEEF;
        vm[6] = 2'b00; va[6] = 32'hFFFF_FFFF; vb[6] = 32'h0000_0100; vr[6] = 32'h0000_0000;
        vm[7] = 2'b01; va[7] = 32'hF0F0_F0F0; vb[7] = 32'd12;        vr[7] = 32'h000F_0F0F;

        reset = 1'b1;
        in_valid = 1'b0; in_mode = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
        in_valid8 = 1'b0; in_mode8 = 2'b00; in_a8 = '0; in_b8 = '0; in_tag8 = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_res", {32'd0, out_res}, 64'd0);
        check("rst_out_tag", {60'd0, out_tag}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid8", {63'd0, out_valid8}, 64'd0);
        @(posedge clk);
        #1;

        send(2'b01, 32'h8000_0000, 32'd31, 4'd1, 32'h0000_0001, 1'b1, 1'b1);
        drain();

        for (int i = 0; i < 8; i++) send(vm[i], va[i], vb[i], 4'(i), vr[i], 1'b1, 1'b1);
        drain();

        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(vm[i], va[i], vb[i], 4'(i + 8), vr[i], 1'b1, 1'b0);
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_cycles", 64'(stall_cnt), 64'd3);

        // Three ops in flight are flushed by reset and must never surface.
        for (int i = 0; i < 3; i++) send(2'b00, 32'h0000_00FF, 32'd1, 4'(12 + i), 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_out_res", {32'd0, out_res}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        send(2'b00, 32'h0000_0001, 32'd4, 4'd9, 32'h0000_0010, 1'b1, 1'b1);
        drain();

        run8("w8_sll1", 8'h81, 32'd1, 8'h02);
        run8("w8_sll8", 8'h81, 32'd8, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width; SHALL be a power of two, 8 to 64.
REQ-002 Parameter TAGW, default 4, width of the user tag carried alongside each operation.
REQ-003 Derived constant SHW = log2(WIDTH), equal to 5 at the default WIDTH; not overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  operation accepted when in_valid and in_ready are both high on a clk edge.
REQ-008 in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-009 in_a  input  WIDTH  value to shift.
REQ-010 in_b  input  32  shift amount; full register operand, upper bits significant.
REQ-011 in_tag  input  TAGW  opaque tag.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_res  output  WIDTH  shifted result.
REQ-015 out_tag  output  TAGW  tag of the result.

Function
REQ-016 Pipeline of SHW registered stages; stage k applies a shift of 2^k when amount bit k is set, stage 0 first.
REQ-017 Define advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational); all stages shift together only when advance is high.
REQ-018 Latency SHALL be exactly SHW cycles from acceptance to out_valid with no stall; throughput of 1 op/cycle while out_ready is held high.
REQ-019 Stages do not collapse bubbles; a bubble (stage valid 0) advances like data.
REQ-020 Out-of-range: if any in_b bit at or above SHW is set, SLL and SRL SHALL give 0, and SRA SHALL give WIDTH copies of in_a[WIDTH-1].
REQ-021 Out-of-range detection SHALL be latched at acceptance and applied at the final stage.
REQ-022 ROR SHALL use in_b mod WIDTH; upper bits ignored.
REQ-023 SRA fill bit = in_a[WIDTH-1], captured at acceptance.
REQ-024 Tag, mode, fill bit and the remaining amount bits SHALL travel with the data through every stage.
REQ-025 While out_valid and !out_ready: out_res and out_tag SHALL hold stable; no stage changes; in_ready low.
REQ-026 Operations SHALL emerge in acceptance order; none dropped or duplicated.

Reset
REQ-027 Reset SHALL clear all stage valid bits, out_valid, out_res and out_tag to 0 on the next clk edge.
REQ-028 Reset SHALL discard operations in flight, overriding all other activity.
REQ-029 in_ready SHALL be high in the first cycle after reset releases.

Structure
REQ-030 The package shift_pkg SHALL hold the mode encodings (SH_SLL, SH_SRL, SH_SRA, SH_ROR) and the stage payload record: valid, mode, fill, oor, tag, data, remaining amount.
REQ-031 There SHALL be one sub-module, shift_stage, parametrised by stage index, containing one mux level plus its register; it SHALL be instantiated SHW times.

Verification
REQ-032 WIDTH=32 SRL: a=0x80000000, b=31, out_ready=1 -> out_res=0x00000001 exactly 5 cycles after acceptance.
REQ-033 SRA out-of-range: a=0x80000000, b=0x00000020 -> 0xFFFFFFFF; SRL with the same operands -> 0x00000000; ROR a=0x12345678, b=36 -> 0x81234567.
REQ-034 Back-to-back stream: 8 ops with tags 0..7 on consecutive cycles -> 8 results on consecutive cycles, tags in order.
REQ-035 Backpressure: drop out_ready for 3 cycles while the pipe is full -> in_ready low for those cycles, out_res stable, no loss, order preserved after release.
REQ-036 Reset mid-stream with 3 ops in flight -> out_valid 0 the next cycle, none of those ops ever emerges, and a fresh op completes in 5 cycles.
REQ-037 WIDTH=8 build: SLL a=0x81, b=1 -> 0x02 after 3 cycles; SLL with b=8 -> 0x00.
